// File: rtl/pulse_element_q.sv
// Queued pulse player: commands select an envelope span in TSLICE-lane RAM,
// which is scaled by an amplitude and emitted with a per-lane phase ramp.
module pulse_element_q #(
  parameter int TSLICE = 4,
  parameter int QBITS  = 4,
  parameter int AW     = 10,
  parameter int DW     = 16,
  parameter int QDEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [63:0]                   command,
  input  logic                          cstrobe,
  input  logic                          abort,
  input  logic [16:0]                   freq,
  input  logic [AW+$clog2(TSLICE)-1:0]  waddr,
  input  logic [2*DW-1:0]               wdata,
  input  logic                          wstrobe,
  output logic [DW*TSLICE-1:0]          xout,
  output logic [DW*TSLICE-1:0]          yout,
  output logic [17*TSLICE-1:0]          phout,
  output logic [QBITS-1:0]              qsel,
  output logic                          valid,
  output logic                          active,
  output logic                          collision,
  output logic                          qfull
);

  localparam int LB  = $clog2(TSLICE);
  localparam int LBW = (LB == 0) ? 1 : LB;
  localparam int CW  = 2*AW + 34 + QBITS;
  localparam int PW  = $clog2(QDEPTH);
  localparam int MW  = DW + 17;
  localparam logic signed [MW-1:0] SAT_MAX = {18'b0, {(DW-1){1'b1}}};
  localparam logic signed [MW-1:0] SAT_MIN = {18'h3FFFF, {(DW-1){1'b0}}};

  if ((2*AW + 35 + QBITS > 64) || (TSLICE != (1 << LB)) || (QDEPTH < 2) ||
      (QDEPTH != (1 << PW))) begin : g_bad_cfg
    $error("pulse_element_q: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  // ---------------- command queue ----------------
  logic [CW-1:0] q_mem [QDEPTH];
  logic [PW:0]   wr_ptr_q, rd_ptr_q;
  logic          q_empty, q_full, push, pop, collision_q;
  logic [CW-1:0] head;
  logic          unused_cmd;

  assign unused_cmd = ^command[63:CW];
  assign q_empty    = (wr_ptr_q == rd_ptr_q);
  assign q_full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push       = cstrobe && !abort && (!q_full || pop);
  assign head       = q_mem[rd_ptr_q[PW-1:0]];

  // NOTE: storage arrays carry no reset; only the pointers and valid bits define state.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr_q[PW-1:0]] <= command[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
    if (reset) collision_q <= 1'b0;
    else       collision_q <= cstrobe && !abort && !push;
  end

  // ---------------- sequencer (stage 1: word address + phase accumulator) ----------------
  state_t           state_q, state_d;
  logic             v1_q, v1_d, hold_q, hold_d, load;
  logic [AW-1:0]    addr_q, addr_d, cnt_q, cnt_d;
  logic [16:0]      ph1_q, ph1_d, step;
  logic [15:0]      amp1_q, amp1_d;
  logic [QBITS-1:0] qsel1_q, qsel1_d;

  // Per-word phase step is TSLICE*freq, a shift since TSLICE is a power of two.
  assign step = 17'(freq << LB);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    v1_d    = 1'b0;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ph1_d   = ph1_q;
    amp1_d  = amp1_q;
    qsel1_d = qsel1_q;
    hold_d  = hold_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: load = !q_empty;
      S_RUN: begin
        if (cnt_q != '0) begin
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q - AW'(1);
          ph1_d  = ph1_q + step;
          v1_d   = 1'b1;
        end else if (!q_empty) begin
          load = 1'b1;
        end else if (hold_q) begin
          state_d = S_HOLD;
          ph1_d   = ph1_q + step;
          v1_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (!q_empty) begin
          load = 1'b1;
        end else begin
          ph1_d = ph1_q + step;
          v1_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      state_d = S_RUN;
      v1_d    = 1'b1;
      addr_d  = head[AW-1:0];
      cnt_d   = head[2*AW-1:AW];
      amp1_d  = head[2*AW+15:2*AW];
      ph1_d   = head[2*AW+32:2*AW+16];
      qsel1_d = head[2*AW+33+QBITS-1:2*AW+33];
      hold_d  = head[2*AW+33+QBITS];
    end
    pop = load && !abort;
    if (abort) begin
      state_d = S_IDLE;
      v1_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      v1_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      ph1_q   <= '0;
      amp1_q  <= '0;
      qsel1_q <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v1_q    <= v1_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ph1_q   <= ph1_d;
      amp1_q  <= amp1_d;
      qsel1_q <= qsel1_d;
      hold_q  <= hold_d;
    end
  end

  // ---------------- stage 2: envelope lane RAMs ----------------
  logic [2*DW-1:0] env_mem [TSLICE][2**AW];
  logic [2*DW-1:0] rd_q [TSLICE];
  logic [LBW-1:0]  wlane;
  logic [AW-1:0]   wword;

  assign wlane = (LB == 0) ? '0 : waddr[LBW-1:0];
  assign wword = waddr[AW+LB-1 -: AW];

  // NOTE: non-blocking write and read in one block give read-first behaviour.
  always_ff @(posedge clk) begin
    for (int k = 0; k < TSLICE; k++) begin
      if (wstrobe && (wlane == LBW'(k))) env_mem[k][wword] <= wdata;
      rd_q[k] <= env_mem[k][addr_q];
    end
  end

  // ---------------- stages 2-4: scale, saturate, register outputs ----------------
  logic                    v2_q, v3_q, valid_q;
  logic [16:0]             ph2_q, ph3_q;
  logic [15:0]             amp2_q;
  logic [QBITS-1:0]        qsel2_q, qsel3_q, qsel_q;
  logic signed [MW-1:0]    prod_x_q [TSLICE];
  logic signed [MW-1:0]    prod_y_q [TSLICE];
  logic [DW*TSLICE-1:0]    xout_q, yout_q;
  logic [17*TSLICE-1:0]    phout_q, lane_ph;

  function automatic logic [DW-1:0] sat(input logic signed [MW-1:0] p);
    logic signed [MW-1:0] s;
    s = p >>> 15;
    if (s > SAT_MAX)      return SAT_MAX[DW-1:0];
    else if (s < SAT_MIN) return SAT_MIN[DW-1:0];
    else                  return s[DW-1:0];
  endfunction

  always_comb begin
    logic [16:0] acc;
    acc     = ph3_q;
    lane_ph = '0;
    for (int k = 0; k < TSLICE; k++) begin
      lane_ph[k*17 +: 17] = acc;
      acc = acc + freq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      valid_q <= 1'b0;
      ph2_q   <= '0;
      ph3_q   <= '0;
      amp2_q  <= '0;
      qsel2_q <= '0;
      qsel3_q <= '0;
      qsel_q  <= '0;
      xout_q  <= '0;
      yout_q  <= '0;
      phout_q <= '0;
      for (int k = 0; k < TSLICE; k++) begin
        prod_x_q[k] <= '0;
        prod_y_q[k] <= '0;
      end
    end else begin
      v2_q    <= v1_q && !abort;
      v3_q    <= v2_q && !abort;
      valid_q <= v3_q && !abort;
      ph2_q   <= ph1_q;
      ph3_q   <= ph2_q;
      amp2_q  <= amp1_q;
      qsel2_q <= qsel1_q;
      qsel3_q <= qsel2_q;
      for (int k = 0; k < TSLICE; k++) begin
        prod_x_q[k] <= MW'($signed(rd_q[k][DW-1:0]))  * MW'($signed({1'b0, amp2_q}));
        prod_y_q[k] <= MW'($signed(rd_q[k][2*DW-1:DW])) * MW'($signed({1'b0, amp2_q}));
      end
      if (v3_q && !abort) begin
        for (int k = 0; k < TSLICE; k++) begin
          xout_q[k*DW +: DW] <= sat(prod_x_q[k]);
          yout_q[k*DW +: DW] <= sat(prod_y_q[k]);
        end
        phout_q <= lane_ph;
        qsel_q  <= qsel3_q;
      end else begin
        xout_q  <= '0;
        yout_q  <= '0;
        phout_q <= '0;
      end
    end
  end

  assign xout      = xout_q;
  assign yout      = yout_q;
  assign phout     = phout_q;
  assign qsel      = qsel_q;
  assign valid     = valid_q;
  assign active    = (state_q != S_IDLE);
  assign collision = collision_q;
  assign qfull     = q_full;

endmodule

// File: doc/pulse_element_q.md
PULSE_ELEMENT_Q -- requirements
Module: pulse_element_q

Interface
REQ-001 Parameter TSLICE, default 4: samples per clock; power of two, 1 allowed.
REQ-002 Parameter QBITS, default 4: width of the channel-select field and output.
REQ-003 Parameter AW, default 10: envelope memory address width, in words of TSLICE samples.
REQ-004 Parameter DW, default 16: signed I and Q sample width.
REQ-005 Parameter QDEPTH, default 4: command queue depth; power of two, at least 2.
REQ-006 Elaboration SHALL fail if 2*AW+35+QBITS > 64.
REQ-007 clk  in  1  single clock; every port is synchronous to its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 command  in  64  fields: [AW-1:0] start word; [2AW-1:AW] length-1; next 16 amp (unsigned Q1.15); next 17 phase0; next QBITS qsel; next 1 hold; next 1 reserved (ignored).
REQ-010 cstrobe  in  1  enqueue command.
REQ-011 abort  in  1  flush the queue and stop playback.
REQ-012 freq  in  17  phase step per sample, static while active.
REQ-013 waddr  in  AW+log2(TSLICE)  sample write address: high bits = word, low bits = lane.
REQ-014 wdata  in  2*DW  {Q,I} sample.
REQ-015 wstrobe  in  1  write enable.
REQ-016 xout, yout  out  DW*TSLICE  scaled I and Q; lane k at bits [k*DW +: DW].
REQ-017 phout  out  17*TSLICE  per-lane phase for the downstream rotator.
REQ-018 qsel  out  QBITS  channel select, aligned with data.
REQ-019 valid  out  1  output word valid.
REQ-020 active  out  1  high while the FSM is not in IDLE.
REQ-021 collision  out  1  one-cycle pulse on a dropped command.
REQ-022 qfull  out  1  command queue full.

Function
REQ-023 Envelope RAM SHALL be TSLICE lane RAMs of depth 2^AW.
REQ-024 Envelope RAM reads SHALL have 1-cycle latency and be read-first on a same-address write; writes are allowed at any time.
REQ-025 A cstrobe with the queue not full, or full but popping in the same cycle, SHALL enqueue the command.
REQ-026 A cstrobe otherwise SHALL drop the command and pulse collision for 1 cycle.
REQ-027 FSM states: IDLE, RUN, HOLD.
REQ-028 In IDLE with the queue non-empty, the FSM SHALL pop one command and enter RUN.
REQ-029 RUN SHALL issue one word address per cycle, start+n mod 2^AW, for n = 0..length-1.
REQ-030 After the last word, a non-empty queue SHALL pop the next command and continue RUN with zero bubble cycles.
REQ-031 After the last word with an empty queue, the FSM SHALL go to HOLD if hold=1, otherwise to IDLE.
REQ-032 HOLD SHALL repeat the last word, with valid=1 and phase still advancing, until the queue is non-empty; it then pops and enters RUN with no gap.
REQ-033 Phase of lane k at word n SHALL be phase0 + (n*TSLICE+k)*freq mod 2^17.
REQ-034 The phase accumulator SHALL be implemented without a multiplier in the loop.
REQ-035 Each output sample SHALL be sat_DW((env*amp) >>> 15), env signed DW and amp unsigned 16.
REQ-036 amp=0x8000 SHALL give unity gain; results SHALL saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-037 Pipeline: pop/load, address register, RAM read, multiply, output register.
REQ-038 The first word of a command enqueued at cycle t into an empty queue with the FSM in IDLE SHALL be valid at cycle t+5.
REQ-039 qsel and phout SHALL be aligned with the data word they describe.
REQ-040 When valid=0, xout, yout and phout SHALL be 0, and qsel SHALL hold its last value.
REQ-041 abort SHALL empty the queue and move the FSM to IDLE.
REQ-042 abort SHALL clear every pipeline valid bit, forcing valid=0 and zero data from the next cycle.
REQ-043 abort and cstrobe in the same cycle: abort wins, the command is discarded, collision=0.
REQ-044 length-1 = 2^AW-1 SHALL play 2^AW words, wrapping the address.

Reset
REQ-045 Reset SHALL give: FSM in IDLE, queue empty, pipeline valid bits cleared, phase accumulator 0.
REQ-046 Reset SHALL give outputs: xout/yout/phout/qsel=0, valid=0, active=0, collision=0, qfull=0.
REQ-047 RAM contents SHALL be unaffected by reset.
REQ-048 Reset asserted mid-playback SHALL take effect on the next edge, overriding all other inputs.

Verification
REQ-049 Load word 5, lane k with I=1000*(k+1), Q=-500; command start=5, len-1=0, amp=0x8000, phase0=0, freq=0x100, hold=0; cstrobe at t -> valid only at t+5, xout lanes=1000,2000,3000,4000, yout=-500, phout=0,0x100,0x200,0x300; then IDLE.
REQ-050 amp=0xFFFF, I=0x7000 -> x saturates to 0x7FFF; I=-0x7000 -> x=-0x8000.
REQ-051 Two commands back-to-back, len-1 = 2 and 1 -> 5 consecutive valid words, no gap, qsel switches exactly on word 4.
REQ-052 Five cstrobes in consecutive cycles with QDEPTH=4, FSM busy -> fifth dropped, one collision pulse, qfull=1 during cycles 4-5.
REQ-053 hold=1, len-1=0 -> valid remains 1 with the repeated word and phout advancing by 4*freq per cycle; abort -> valid=0 the next cycle, active=0.
REQ-054 start=2^AW-1, len-1=1 -> words 2^AW-1 then 0; write to word 0 in the same cycle it is read -> old data output.
